// File: rtl/compare_serial.sv
// Multi-cycle RISC-V branch comparator: evaluates EQ/NE/LT/GE/LTU/GEU on N-bit operands,
// CHUNK bits per cycle, MSB-first. Define COMPARE_SERIAL_EARLY_EXIT_EN to finish on the first differing chunk.
module compare_serial #(
   parameter int N     = 32,  // operand width, N >= 2
   parameter int CHUNK = 8    // N must be a multiple of CHUNK
) (
   input  logic         clk_i,
   input  logic         rstn_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic [2:0]   op_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic         res_o,
   output logic         busy_o
);

   localparam int ITER = N / CHUNK;
   localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CW-1:0] CNT_TOP = CW'(ITER - 1);

   localparam logic [2:0] OP_EQ  = 3'b000;
   localparam logic [2:0] OP_NE  = 3'b001;
   localparam logic [2:0] OP_LT  = 3'b100;
   localparam logic [2:0] OP_GE  = 3'b101;
   localparam logic [2:0] OP_LTU = 3'b110;
   localparam logic [2:0] OP_GEU = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   logic [N-1:0]    r_a;
   logic [N-1:0]    r_b;
   logic [2:0]      r_op;
   logic [CW-1:0]   r_cnt;
   logic            r_decided;
   logic            r_lt;
   logic            r_out_valid;
   logic            r_res;

   logic            w_signed;
   logic [N-1:0]    w_sign_mask;
   logic [N-1:0]    w_a_shift;
   logic [N-1:0]    w_b_shift;
   logic [CHUNK-1:0] w_a_chunk;
   logic [CHUNK-1:0] w_b_chunk;
   logic            w_hit;
   logic            w_decided_nxt;
   logic            w_lt_nxt;
   logic            w_last;

   // Flipping the sign bit of both operands maps signed order onto unsigned order.
   assign w_signed    = (op_i == OP_LT) || (op_i == OP_GE);
   assign w_sign_mask = {w_signed, {(N-1){1'b0}}};

   assign w_a_shift = r_a >> (CHUNK * int'(r_cnt));
   assign w_b_shift = r_b >> (CHUNK * int'(r_cnt));
   assign w_a_chunk = w_a_shift[CHUNK-1:0];
   assign w_b_chunk = w_b_shift[CHUNK-1:0];

   // Only the first (most significant) differing chunk decides the ordering.
   assign w_hit         = !r_decided && (w_a_chunk != w_b_chunk);
   assign w_decided_nxt = r_decided | w_hit;
   assign w_lt_nxt      = w_hit ? (w_a_chunk < w_b_chunk) : r_lt;

`ifdef COMPARE_SERIAL_EARLY_EXIT_EN
   assign w_last = (r_cnt == '0) || w_hit;
`else
   assign w_last = (r_cnt == '0);
`endif

   function automatic logic eval_cond(input logic [2:0] op, input logic decided, input logic lt);
      logic eq;
      eq = !decided;
      case (op)
         OP_EQ:          eval_cond = eq;
         OP_NE:          eval_cond = !eq;
         OP_LT, OP_LTU:  eval_cond = lt;
         OP_GE, OP_GEU:  eval_cond = !lt;
         default:        eval_cond = 1'b0;
      endcase
   endfunction

   // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= '0;
         r_cnt       <= '0;
         r_decided   <= 1'b0;
         r_lt        <= 1'b0;
         r_out_valid <= 1'b0;
         r_res       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid_i) begin
                  r_a       <= a_i ^ w_sign_mask;
                  r_b       <= b_i ^ w_sign_mask;
                  r_op      <= op_i;
                  r_cnt     <= CNT_TOP;
                  r_decided <= 1'b0;
                  r_lt      <= 1'b0;
                  r_state   <= S_RUN;
               end
            end
            S_RUN: begin
               r_decided <= w_decided_nxt;
               r_lt      <= w_lt_nxt;
               if (w_last) begin
                  r_state     <= S_DONE;
                  r_out_valid <= 1'b1;
                  r_res       <= eval_cond(r_op, w_decided_nxt, w_lt_nxt);
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready_i) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready_o  = (r_state == S_IDLE);
   assign busy_o      = (r_state != S_IDLE);
   assign out_valid_o = r_out_valid;
   assign res_o       = r_res;

endmodule

// File: tb/tb_compare_serial.sv
// Directed self-checking bench for compare_serial (N=32, CHUNK=8); expected latencies
// follow COMPARE_SERIAL_EARLY_EXIT_EN when it is defined.
module tb_compare_serial;

   localparam int N = 32;
`ifdef COMPARE_SERIAL_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic         clk_i = 1'b0;
   logic         rstn_i;
   logic         in_valid_i;
   logic         in_ready_o;
   logic [N-1:0] a_i;
   logic [N-1:0] b_i;
   logic [2:0]   op_i;
   logic         out_valid_o;
   logic         out_ready_i;
   logic         res_o;
   logic         busy_o;

   int n_checks = 0;
   int n_errors = 0;

   compare_serial #(.N(N), .CHUNK(8)) dut (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .a_i         (a_i),
      .b_i         (b_i),
      .op_i        (op_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .res_o       (res_o),
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Accept one op, then count edges until out_valid_o rises (bounded).
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic exp_res, input int exp_lat);
      int lat;
      @(negedge clk_i);
      check({tag, " ready"}, 32'(in_ready_o), 32'd1);
      a_i = a; b_i = b; op_i = op; in_valid_i = 1'b1;
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
      check({tag, " busy"}, 32'(busy_o), 32'd1);
      lat = 0;
      while (!out_valid_o && lat < 20) begin
         @(posedge clk_i); #1;
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " res"}, 32'(res_o), 32'(exp_res));
   endtask

   task automatic release_result(input string tag);
      @(negedge clk_i);
      out_ready_i = 1'b1;
      @(posedge clk_i); #1;
      out_ready_i = 1'b0;
      check({tag, " idle valid"}, 32'(out_valid_o), 32'd0);
      check({tag, " idle ready"}, 32'(in_ready_o), 32'd1);
   endtask

   initial begin
      rstn_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
      a_i = '0; b_i = '0; op_i = '0;
      #12;
      check("rst out_valid", 32'(out_valid_o), 32'd0);
      check("rst res",       32'(res_o),       32'd0);
      check("rst busy",      32'(busy_o),      32'd0);
      check("rst in_ready",  32'(in_ready_o),  32'd1);
      @(negedge clk_i);
      rstn_i = 1'b1;

      // 1: signed vs unsigned view of 0xFFFFFFFF vs 1
      run_op("lt_neg", 32'hFFFFFFFF, 32'h00000001, 3'b100, 1'b1, EARLY ? 1 : 4);
      release_result("lt_neg");
      run_op("ltu_big", 32'hFFFFFFFF, 32'h00000001, 3'b110, 1'b0, EARLY ? 1 : 4);
      release_result("ltu_big");

      // 2: equal operands always take the full scan
      run_op("eq_same", 32'h12345678, 32'h12345678, 3'b000, 1'b1, 4);
      release_result("eq_same");
      run_op("ne_same", 32'h12345678, 32'h12345678, 3'b001, 1'b0, 4);
      release_result("ne_same");
      run_op("ge_same", 32'h12345678, 32'h12345678, 3'b101, 1'b1, 4);
      release_result("ge_same");
      run_op("ltu_same", 32'h12345678, 32'h12345678, 3'b110, 1'b0, 4);
      release_result("ltu_same");

      // 3: sign boundary and LSB-chunk difference
      run_op("ge_min", 32'h80000000, 32'h7FFFFFFF, 3'b101, 1'b0, EARLY ? 1 : 4);
      release_result("ge_min");
      run_op("geu_min", 32'h80000000, 32'h7FFFFFFF, 3'b111, 1'b1, EARLY ? 1 : 4);
      release_result("geu_min");
      run_op("ltu_mid", 32'h12345678, 32'h12005678, 3'b110, 1'b0, EARLY ? 2 : 4);
      release_result("ltu_mid");
      run_op("lt_lsb", 32'h00000100, 32'h00000101, 3'b100, 1'b1, 4);

      // 4: backpressure holds the result while inputs wiggle
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         a_i = ~a_i; b_i = ~b_i; op_i = 3'b000; in_valid_i = 1'b1;
         @(posedge clk_i); #1;
         check("bp valid",    32'(out_valid_o), 32'd1);
         check("bp res",      32'(res_o),       32'd1);
         check("bp in_ready", 32'(in_ready_o),  32'd0);
      end
      in_valid_i = 1'b0;
      release_result("bp");
      run_op("ne_b2b", 32'h00000001, 32'h00000002, 3'b001, 1'b1, 4);
      release_result("ne_b2b");

      // 5: illegal op yields 0, next op unaffected
      run_op("illegal", 32'h00000005, 32'h00000003, 3'b010, 1'b0, 4);
      release_result("illegal");
      run_op("ltu_after", 32'h00000003, 32'h00000005, 3'b110, 1'b1, 4);
      release_result("ltu_after");

      // 6: asynchronous reset in the middle of RUN
      @(negedge clk_i);
      a_i = 32'h0000AAAA; b_i = 32'h0000AAAA; op_i = 3'b000; in_valid_i = 1'b1;
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
      @(posedge clk_i); #1;
      @(posedge clk_i); #2;
      rstn_i = 1'b0;
      #1;
      check("arst valid",    32'(out_valid_o), 32'd0);
      check("arst busy",     32'(busy_o),      32'd0);
      check("arst in_ready", 32'(in_ready_o),  32'd1);
      @(negedge clk_i);
      rstn_i = 1'b1;
      run_op("eq_zero", 32'h00000000, 32'h00000000, 3'b000, 1'b1, 4);
      release_result("eq_zero");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
